// File: rtl/xor_frame_accum.sv
// Streaming XOR-reduction of valid/ready framed words into a parity word,
// with saturating word count and overflow flag per frame.
module xor_frame_accum #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             odd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_parity,
  output logic             out_bit,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic             accept;
  logic             cnt_at_max;
  logic [CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0] acc_next;

  // A pending result blocks new words only while downstream stalls
  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign out_bit    = ^out_parity;

  always_comb begin
    cnt_at_max = (cnt == CNT_W'(MAX_LEN));
    cnt_next   = cnt_at_max ? CNT_W'(MAX_LEN) : cnt + CNT_W'(1);
    acc_next   = acc ^ in_data;
  end

  // Frame accumulation and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
      out_parity <= '0;
      out_count  <= '0;
      out_ovf    <= 1'b0;
    end else begin
      if (accept && in_last) begin
        out_parity <= acc_next ^ {WIDTH{odd_mode}};
        out_count  <= cnt_next;
        out_ovf    <= ovf || cnt_at_max;
        out_valid  <= 1'b1;
        acc        <= '0;
        cnt        <= '0;
        ovf        <= 1'b0;
      end else begin
        if (accept) begin
          acc <= acc_next;
          cnt <= cnt_next;
          if (cnt_at_max) begin
            ovf <= 1'b1;
          end
        end
        if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_xor_frame_accum.sv
// Self-checking bench for xor_frame_accum: directed table, corner sequences,
// and random traffic against a frame-level queue model.
module tb_xor_frame_accum;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             odd_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_parity;
  logic             out_bit;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  int total = 0;
  int bad   = 0;

  // Reference model: words of the open frame plus the expected pending result
  logic [WIDTH-1:0] frame_q[$];
  logic             exp_valid;
  logic [WIDTH-1:0] exp_parity;
  logic [CNT_W-1:0] exp_count;
  logic             exp_ovf;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       odd;
    logic [7:0] parity;
    int         count;
    logic       ovf;
    logic       pbit;
  } vec_t;

  vec_t vecs[10];

  xor_frame_accum #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .odd_mode   (odd_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_parity (out_parity),
    .out_bit    (out_bit),
    .out_count  (out_count),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // One clock: predict from the currently driven inputs, clock, then compare
  task automatic cycle();
    logic       acc;
    logic [7:0] p;
    int         n;
    #1;
    check("in_ready", 32'(in_ready), 32'(!exp_valid || out_ready));
    acc = in_valid && (!exp_valid || out_ready);
    if (acc && in_last) begin
      frame_q.push_back(in_data);
      p = odd_mode ? 8'hFF : 8'h00;
      foreach (frame_q[i]) p ^= frame_q[i];
      n = frame_q.size();
      exp_parity = p;
      exp_count  = CNT_W'((n > int'(MAX_LEN)) ? int'(MAX_LEN) : n);
      exp_ovf    = (n > int'(MAX_LEN));
      exp_valid  = 1'b1;
      frame_q.delete();
    end else begin
      if (acc) frame_q.push_back(in_data);
      if (out_ready) exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("out_parity", 32'(out_parity), 32'(exp_parity));
      check("out_count", 32'(out_count), 32'(exp_count));
      check("out_ovf", 32'(out_ovf), 32'(exp_ovf));
      check("out_bit", 32'(out_bit), 32'(^exp_parity));
    end
  endtask

  task automatic word(input logic [7:0] d, input logic l, input logic o);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    odd_mode = o;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_parity", 32'(out_parity), 32'd0);
    check("rst out_bit", 32'(out_bit), 32'd0);
    check("rst out_count", 32'(out_count), 32'd0);
    check("rst out_ovf", 32'(out_ovf), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);
    frame_q.delete();
    exp_valid  = 1'b0;
    exp_parity = '0;
    exp_count  = '0;
    exp_ovf    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    odd_mode  = 1'b0;
    out_ready = 1'b1;
    exp_valid = 1'b0;

    vecs[0] = '{8'h0F, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0};
    vecs[1] = '{8'hF0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 8'hC3, 3, 1'b0, 1'b0};
    vecs[3] = '{8'h0F, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0};
    vecs[4] = '{8'hF0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0};
    vecs[5] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 3, 1'b0, 1'b0};
    vecs[6] = '{8'h81, 1'b1, 1'b0, 8'h81, 1, 1'b0, 1'b0};
    vecs[7] = '{8'h07, 1'b1, 1'b1, 8'hF8, 1, 1'b0, 1'b1};
    vecs[8] = '{8'h12, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0};
    vecs[9] = '{8'h34, 1'b1, 1'b0, 8'h26, 2, 1'b0, 1'b1};

    apply_reset();

    out_ready = 1'b1;
    foreach (vecs[i]) begin
      word(vecs[i].data, vecs[i].last, vecs[i].odd);
      if (vecs[i].last) begin
        check($sformatf("tbl%0d valid", i), 32'(out_valid), 32'd1);
        check($sformatf("tbl%0d parity", i), 32'(out_parity), 32'(vecs[i].parity));
        check($sformatf("tbl%0d count", i), 32'(out_count), 32'(vecs[i].count));
        check($sformatf("tbl%0d ovf", i), 32'(out_ovf), 32'(vecs[i].ovf));
        check($sformatf("tbl%0d bit", i), 32'(out_bit), 32'(vecs[i].pbit));
      end
    end
    cycle();

    // Overflow: 17 words into a 16-word limit, then a clean single-word frame
    for (int i = 1; i <= 17; i++) word(8'h01, (i == 17), 1'b0);
    check("ovf parity", 32'(out_parity), 32'h01);
    check("ovf count", 32'(out_count), 32'd16);
    check("ovf flag", 32'(out_ovf), 32'd1);
    word(8'hAA, 1'b1, 1'b0);
    check("post-ovf parity", 32'(out_parity), 32'hAA);
    check("post-ovf count", 32'(out_count), 32'd1);
    check("post-ovf flag", 32'(out_ovf), 32'd0);
    cycle();

    // Backpressure: result held, offered words refused
    out_ready = 1'b0;
    word(8'h55, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h77;
      in_last  = 1'b1;
      cycle();
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp valid", 32'(out_valid), 32'd1);
      check("bp parity", 32'(out_parity), 32'h55);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", 32'(in_ready), 32'd1);
    cycle();
    check("bp consumed", 32'(out_valid), 32'd0);

    // Back-to-back single-word frames
    word(8'h01, 1'b1, 1'b0);
    check("b2b0 valid", 32'(out_valid), 32'd1);
    check("b2b0 parity", 32'(out_parity), 32'h01);
    word(8'h02, 1'b1, 1'b0);
    check("b2b1 valid", 32'(out_valid), 32'd1);
    check("b2b1 parity", 32'(out_parity), 32'h02);
    word(8'h04, 1'b1, 1'b0);
    check("b2b2 valid", 32'(out_valid), 32'd1);
    check("b2b2 parity", 32'(out_parity), 32'h04);
    check("b2b2 count", 32'(out_count), 32'd1);
    cycle();

    // Reset in the middle of a frame discards it
    word(8'h11, 1'b0, 1'b0);
    word(8'h22, 1'b0, 1'b0);
    apply_reset();
    word(8'h81, 1'b1, 1'b0);
    check("post-rst parity", 32'(out_parity), 32'h81);
    check("post-rst count", 32'(out_count), 32'd1);
    cycle();

    // Random traffic: short frames, then long frames that often overflow
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 1500; i++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_data   = 8'($urandom);
        in_last   = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 24) == 0);
        odd_mode  = 1'($urandom);
        out_ready = ($urandom_range(0, 9) < 7);
        cycle();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xor_frame_accum.md
# xor_frame_accum

Streaming, parametrised successor to the two-input XOR gate. The block XOR-reduces a frame of WIDTH-bit words into one parity word, counts the words in the frame, and flags frames longer than MAX_LEN. It sits between a word source and a checker or packer. Both sides use valid/ready handshakes.

## Interface
Parameters:
- WIDTH, 8, data and parity word width (≥1)
- MAX_LEN, 16, maximum legal words per frame (≥1)
- CNT_W, $clog2(MAX_LEN+1), word-count width (derived; do not override)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  WIDTH  input word
- in_last  in  1  marks the final word of the frame
- odd_mode  in  1  sampled with the last word; 1 = invert the result (odd parity)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_parity  out  WIDTH  XOR of all words in the frame, inverted if odd_mode
- out_bit  out  1  XOR-reduction of out_parity
- out_count  out  CNT_W  words in the frame, saturating at MAX_LEN
- out_ovf  out  1  frame had more than MAX_LEN words

## Operation
- Single clock domain. Reset is asynchronous and active-low, with clock clk and reset rst_n.
- Internal state: accumulator acc[WIDTH], counter cnt[CNT_W], sticky flag ovf. Output registers hold out_*.
- in_ready = !out_valid || out_ready. This is purely combinational from registers and out_ready, and does not depend on in_valid.
- A word is accepted when in_valid && in_ready.
- Accepted word, in_last=0:
  - acc <= acc ^ in_data.
  - cnt <= (cnt==MAX_LEN) ? MAX_LEN : cnt+1.
  - If cnt==MAX_LEN before this word, ovf <= 1.
- Accepted word, in_last=1:
  - out_parity <= acc ^ in_data ^ {WIDTH{odd_mode}}.
  - out_count <= saturated cnt+1.
  - out_ovf <= ovf || (cnt==MAX_LEN).
  - out_valid <= 1.
  - acc, cnt and ovf clear to 0 in the same edge.
- A single-word frame (first word has in_last=1) is legal: out_count=1.
- Output handshake: the result is consumed when out_valid && out_ready. If no new last word is accepted in that cycle, out_valid <= 0.
- Simultaneous output consume and accepted last word: out_valid stays 1 and the out_* registers load the new result. This gives one frame per cycle throughput.
- While out_valid=1 and out_ready=0:
  - in_ready=0. No words are accepted, including non-last words.
  - out_* hold stable.
- out_bit = ^out_parity (combinational from the register).
- in_data, in_last and odd_mode are ignored when a word is not accepted.
- Reset mid-frame discards the partial frame and any pending result. No output is generated for the discarded data.

## Timing
- Reset values: in_ready=1, out_valid=0, out_parity=0, out_bit=0, out_count=0, out_ovf=0. Internal acc, cnt and ovf are 0.
- Latency: the result is visible 1 cycle after the edge that accepts the last word.
- Throughput: 1 word per cycle with out_ready held high. Back-to-back single-word frames give out_valid high every cycle.
- Backpressure: in_ready falls in the same cycle that out_valid=1 and out_ready=0. It rises combinationally when out_ready rises.
- Count wrap: cnt never wraps. It saturates at MAX_LEN, and ovf is set by word MAX_LEN+1.
- Async reset takes effect immediately, without waiting for a clock edge. Deassertion is synchronised externally.

## Test plan
- Reset, then frame 0x0F, 0xF0, 0x3C (last), odd_mode=0, out_ready=1 -> one cycle after the last word: out_parity=0xC3, out_bit=0, out_count=3, out_ovf=0.
- Same frame with odd_mode=1 -> out_parity=0x3C, out_bit=0.
- 17 words of 0x01 with MAX_LEN=16, last on word 17 -> out_parity=0x01, out_count=16, out_ovf=1. The next frame (0xAA, last) gives out_ovf=0, out_count=1.
- Backpressure: frame 0x55 (last) with out_ready=0 for 4 cycles -> out_valid=1 and out_parity=0x55 stay stable, in_ready=0, and offered words are not consumed. Raise out_ready -> result consumed, in_ready=1.
- Back-to-back single-word frames 0x01, 0x02, 0x04 with out_ready=1 -> out_valid high for 3 consecutive cycles, out_parity=0x01, 0x02, 0x04, out_count=1 each.
- Assert rst_n=0 after 2 words of a frame, then release -> all outputs return to reset values. The next frame 0x81 (last) gives out_parity=0x81, out_count=1.
